// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-generator pipeline.
// Optional illegal-format counter is enabled with the IMM_ILLEGAL_CNT_EN macro.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_U     = 3'b100,
        IMM_Z     = 3'b101,
        IMM_SHAMT = 3'b110,
        ILLEGAL   = 3'b111
    } imm_src_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    localparam int ILLEGAL_CNT_W = 16;

endpackage

// File: rtl/imm_format.sv
// Combinational RISC-V immediate formatter: extracts and extends the immediate
// selected by imm_src; the reserved code yields zero and flags illegal.
module imm_format
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Sign-extending formats are first built as 32-bit values, then widened.
    logic [31:0] raw32;

    // NOTE: every output of an always_comb gets a default first so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        raw32   = '0;
        imm     = '0;
        illegal = 1'b0;
        case (imm_src_t'(imm_src))
            IMM_I: begin
                raw32 = {{20{instr[31]}}, instr[31:20]};
                imm   = XLEN'($signed(raw32));
            end
            IMM_S: begin
                raw32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                imm   = XLEN'($signed(raw32));
            end
            IMM_B: begin
                raw32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                imm   = XLEN'($signed(raw32));
            end
            IMM_J: begin
                raw32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                imm   = XLEN'($signed(raw32));
            end
            IMM_U: begin
                raw32 = {instr[31:12], 12'b0};
                imm   = XLEN'($signed(raw32));
            end
            IMM_Z:     imm = XLEN'(instr[19:15]);
            IMM_SHAMT: imm = (XLEN == 32) ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator followed by a 2-entry FIFO skid buffer with registered in_ready.
// Define IMM_ILLEGAL_CNT_EN to add the saturating illegal_cnt output.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [2:0]               in_imm_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_imm,
    output logic                     out_illegal
`ifdef IMM_ILLEGAL_CNT_EN
    ,
    output logic [ILLEGAL_CNT_W-1:0] illegal_cnt
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] fmt_imm;
    logic            fmt_illegal;

    imm_format #(.XLEN(XLEN)) u_imm_format (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (fmt_imm),
        .illegal (fmt_illegal)
    );

    buf_state_t      state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [XLEN-1:0] head_imm_q, head_imm_d, tail_imm_q, tail_imm_d;
    logic            head_ill_q, head_ill_d, tail_ill_q, tail_ill_d;
    logic            push, pop;

    assign push = in_valid & in_ready_q;
    assign pop  = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d    = state_q;
        head_imm_d = head_imm_q;
        head_ill_d = head_ill_q;
        tail_imm_d = tail_imm_q;
        tail_ill_d = tail_ill_q;
        case (state_q)
            EMPTY: if (push) begin
                state_d    = ONE;
                head_imm_d = fmt_imm;
                head_ill_d = fmt_illegal;
            end
            ONE: begin
                if (push && pop) begin
                    head_imm_d = fmt_imm;
                    head_ill_d = fmt_illegal;
                end else if (push) begin
                    state_d    = TWO;
                    tail_imm_d = fmt_imm;
                    tail_ill_d = fmt_illegal;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: if (pop) begin
                state_d    = ONE;
                head_imm_d = tail_imm_q;
                head_ill_d = tail_ill_q;
            end
            default: state_d = EMPTY;
        endcase
        // Registered ready: decided from the next state, never from out_ready directly.
        in_ready_d = (state_d != TWO);
    end

    // NOTE: state is updated with non-blocking assignments and a synchronous
    // active-low reset, so every flop samples rst_n only on the rising edge.
    // NOTE: the entry registers are reset as well, because out_imm/out_illegal
    // must read zero straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            head_imm_q <= '0;
            head_ill_q <= 1'b0;
            tail_imm_q <= '0;
            tail_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_imm_q <= head_imm_d;
            head_ill_q <= head_ill_d;
            tail_imm_q <= tail_imm_d;
            tail_ill_q <= tail_ill_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_imm     = head_imm_q;
    assign out_illegal = head_ill_q;

`ifdef IMM_ILLEGAL_CNT_EN
    logic [ILLEGAL_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push && fmt_illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe, exercising XLEN=32 and XLEN=64
// instances in lockstep; counter checks compile in with IMM_ILLEGAL_CNT_EN.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
`ifdef IMM_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt32, illegal_cnt64;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready32),
        .in_instr    (in_instr),
        .in_imm_src  (in_imm_src),
        .out_valid   (out_valid32),
        .out_ready   (out_ready),
        .out_imm     (out_imm32),
        .out_illegal (out_illegal32)
`ifdef IMM_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt32)
`endif
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready64),
        .in_instr    (in_instr),
        .in_imm_src  (in_imm_src),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .out_imm     (out_imm64),
        .out_illegal (out_illegal64)
`ifdef IMM_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt64)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle with out_ready high, then check both widths.
    task automatic fmt_vec(input string tag, input logic [31:0] instr, input logic [2:0] src,
                           input logic [31:0] exp32, input logic [63:0] exp64, input logic exp_ill);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_imm_src = src;
        step();
        in_valid = 1'b0;
        check({tag, " valid"}, {63'd0, out_valid32}, 64'd1);
        check({tag, " imm32"}, {32'd0, out_imm32}, {32'd0, exp32});
        check({tag, " imm64"}, out_imm64, exp64);
        check({tag, " ill32"}, {63'd0, out_illegal32}, {63'd0, exp_ill});
        check({tag, " ill64"}, {63'd0, out_illegal64}, {63'd0, exp_ill});
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_imm_src = '0;
        out_ready  = 1'b1;
        #1;
        step();
        step();
        check("rst in_ready", {63'd0, in_ready32}, 64'd0);
        check("rst out_valid", {63'd0, out_valid32}, 64'd0);
        check("rst out_imm", {32'd0, out_imm32}, 64'd0);
        check("rst out_illegal", {63'd0, out_illegal32}, 64'd0);
        rst_n = 1'b1;
        step();
        check("post-rst in_ready", {63'd0, in_ready32}, 64'd1);
        check("post-rst out_valid", {63'd0, out_valid64}, 64'd0);

        // Back-to-back formats with out_ready high (push+pop in ONE keeps the newest at the head).
        fmt_vec("I neg1",  32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        fmt_vec("S neg4",  32'hFE112E23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        fmt_vec("B neg4",  32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        fmt_vec("J pos16", 32'h0100006F, 3'b011, 32'h00000010, 64'h0000000000000010, 1'b0);
        fmt_vec("U pos",   32'h123450B7, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0);
        fmt_vec("Z uimm",  32'h000FD073, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0);
        fmt_vec("SHAMT",   32'h03F0D093, 3'b110, 32'h0000001F, 64'h000000000000003F, 1'b0);
        fmt_vec("ILLEGAL", 32'hFFFFFFFF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1);
        step();
        check("drain out_valid", {63'd0, out_valid32}, 64'd0);

        // Back-pressure: two entries accepted, third held upstream, then ordered drain.
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_imm_src = 3'b000;
        in_instr   = 32'h00100093;
        step();
        in_instr = 32'h00200093;
        step();
        check("bp in_ready two", {63'd0, in_ready32}, 64'd0);
        in_instr = 32'h00300093;
        step();
        check("bp hold in_ready", {63'd0, in_ready32}, 64'd0);
        check("bp hold valid", {63'd0, out_valid32}, 64'd1);
        check("bp hold imm A", {32'd0, out_imm32}, 64'd1);
        out_ready = 1'b1;
        step();
        check("bp drain B", {32'd0, out_imm32}, 64'd2);
        check("bp in_ready back", {63'd0, in_ready32}, 64'd1);
        step();
        in_valid = 1'b0;
        check("bp drain C valid", {63'd0, out_valid32}, 64'd1);
        check("bp drain C", {32'd0, out_imm32}, 64'd3);
        step();
        check("bp empty", {63'd0, out_valid32}, 64'd0);

        // Reset while holding two entries discards both.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00700093;
        step();
        in_instr = 32'h00800093;
        step();
        in_valid = 1'b0;
        check("mid two in_ready", {63'd0, in_ready32}, 64'd0);
        rst_n = 1'b0;
        step();
        check("mid rst out_valid", {63'd0, out_valid32}, 64'd0);
        check("mid rst in_ready", {63'd0, in_ready32}, 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("mid rel in_ready", {63'd0, in_ready32}, 64'd1);
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        step();
        in_valid = 1'b0;
        check("mid new valid", {63'd0, out_valid32}, 64'd1);
        check("mid new imm", {32'd0, out_imm32}, 64'd5);
        step();
        check("mid no stale", {63'd0, out_valid32}, 64'd0);

`ifdef IMM_ILLEGAL_CNT_EN
        // Counter: three illegal pushes, then drive it to saturation and one beyond.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("cnt after rst", {48'd0, illegal_cnt32}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            fmt_vec("cnt ill", 32'h12345678, 3'b111, 32'h0, 64'h0, 1'b1);
        end
        check("cnt three", {48'd0, illegal_cnt32}, 64'd3);
        check("cnt three 64", {48'd0, illegal_cnt64}, 64'd3);
        in_valid   = 1'b1;
        in_imm_src = 3'b111;
        for (int i = 0; i < 65532; i++) begin
            step();
        end
        in_valid = 1'b0;
        check("cnt at max", {48'd0, illegal_cnt32}, 64'hFFFF);
        fmt_vec("cnt sat push", 32'h0, 3'b111, 32'h0, 64'h0, 1'b1);
        check("cnt saturated", {48'd0, illegal_cnt32}, 64'hFFFF);
        fmt_vec("cnt legal push", 32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        check("cnt legal no inc", {48'd0, illegal_cnt64}, 64'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
